scalar_wb_arb_nq: RTL and testbench

Parametrised scalar writeback arbiter for the compute unit: merges one non-stallable bypass source (LSU load return) and `NUM_SRC` stallable sources (FP, VALU-to-scalar, ALU, ...) onto the single scalar regfile write port. Sources that lose arbitration are parked in a `PEND_DEPTH`-entry FIFO and retire in order. It adds x0-write elision and a per-register pending-busy bitmap for the issue scoreboard, and supersedes the fixed 3-source/4-deep arbiter.

---
 rtl/scalar_wb_arb_nq.sv | 224 ++++++++++++++++++++++
 tb/tb_scalar_wb_arb_nq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_wb_arb_nq.sv
// Scalar writeback arbiter.
// Merges a never-stalling bypass source and NUM_SRC stallable sources onto
// the single scalar regfile write port. Requests that lose the port are
// parked in a small in-order FIFO that retires ahead of any new direct source.
module scalar_wb_arb_nq #(
    parameter int NUM_SRC    = 3,
    parameter int DATA_W     = 32,
    parameter int PEND_DEPTH = 4,
    parameter int SRC_W      = $clog2(NUM_SRC + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          byp_valid,
    input  logic [4:0]                    byp_rd,
    input  logic [DATA_W-1:0]             byp_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [5*NUM_SRC-1:0]          src_rd,
    input  logic [DATA_W*NUM_SRC-1:0]     src_data,
    input  logic [NUM_SRC-1:0]            src_ovf,
    input  logic [NUM_SRC-1:0]            src_inv,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          s_we,
    output logic [4:0]                    s_waddr,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [SRC_W-1:0]              wb_src,
    output logic                          wb_err_ovf,
    output logic                          wb_err_inv,
    output logic [$clog2(PEND_DEPTH+1)-1:0] pend_count,
    output logic [31:0]                   pend_busy,
    output logic                          idle
);

    localparam int CNT_W = $clog2(PEND_DEPTH + 1);
    localparam int PTR_W = $clog2(PEND_DEPTH);

    // FIFO control state
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // FIFO payload (not reset; validity comes from head/count)
    logic [4:0]        ent_rd_q   [PEND_DEPTH];
    logic [DATA_W-1:0] ent_data_q [PEND_DEPTH];
    logic [SRC_W-1:0]  ent_src_q  [PEND_DEPTH];
    logic              ent_ovf_q  [PEND_DEPTH];
    logic              ent_inv_q  [PEND_DEPTH];

    logic [PEND_DEPTH-1:0] ent_we;
    logic [4:0]        ent_rd_d   [PEND_DEPTH];
    logic [DATA_W-1:0] ent_data_d [PEND_DEPTH];
    logic [SRC_W-1:0]  ent_src_d  [PEND_DEPTH];
    logic              ent_ovf_d  [PEND_DEPTH];
    logic              ent_inv_d  [PEND_DEPTH];

    // Unpacked views of the per-source buses
    logic [4:0]        src_rd_a   [NUM_SRC];
    logic [DATA_W-1:0] src_data_a [NUM_SRC];

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
            assign src_rd_a[gi]   = src_rd[5*gi +: 5];
            assign src_data_a[gi] = src_data[DATA_W*gi +: DATA_W];
        end
    endgenerate

    // While rst is high the outputs behave as if the FIFO were already empty
    logic [CNT_W-1:0] eff_count;
    logic [PTR_W-1:0] eff_head;
    logic [PTR_W-1:0] eff_tail;
    logic             fifo_empty;
    logic             byp_act;
    logic             pop;
    logic             win_found;
    logic [NUM_SRC-1:0] src_act;
    logic [NUM_SRC-1:0] win_vec;
    logic [NUM_SRC-1:0] acc_vec;
    int               rank_a [NUM_SRC];
    int               n_acc;
    int               slots;
    int               off;

    // Arbitration, loser acceptance, write-port mux and FIFO next state
    always_comb begin
        eff_count  = rst ? '0 : count_q;
        eff_head   = rst ? '0 : head_q;
        eff_tail   = rst ? '0 : tail_q;
        fifo_empty = (eff_count == '0);
        // x0 requests are invisible to arbitration
        byp_act    = byp_valid && (byp_rd != 5'd0);
        pop        = !byp_act && !fifo_empty;

        for (int i = 0; i < NUM_SRC; i++) begin
            src_act[i] = src_valid[i] && (src_rd_a[i] != 5'd0);
        end

        // Direct win only with an idle bypass and nothing parked ahead
        win_found = 1'b0;
        win_vec   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!win_found && src_act[i] && !byp_act && fifo_empty) begin
                win_found  = 1'b1;
                win_vec[i] = 1'b1;
            end
        end

        // Losers take free slots in ascending index order
        slots   = PEND_DEPTH - int'(eff_count) + (pop ? 1 : 0);
        n_acc   = 0;
        acc_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rank_a[i] = 0;
            if (src_act[i] && !win_vec[i] && (slots > n_acc)) begin
                acc_vec[i] = 1'b1;
                rank_a[i]  = n_acc;
                n_acc      = n_acc + 1;
            end
        end

        src_ready = ~src_act | win_vec | acc_vec;

        // Write port: bypass, then FIFO head, then direct winner
        s_we       = 1'b0;
        s_waddr    = '0;
        s_wdata    = '0;
        wb_src     = '0;
        wb_err_ovf = 1'b0;
        wb_err_inv = 1'b0;
        if (byp_act) begin
            s_we    = 1'b1;
            s_waddr = byp_rd;
            s_wdata = byp_data;
            wb_src  = SRC_W'(NUM_SRC);
        end else if (pop) begin
            s_we       = 1'b1;
            s_waddr    = ent_rd_q[eff_head];
            s_wdata    = ent_data_q[eff_head];
            wb_src     = ent_src_q[eff_head];
            wb_err_ovf = ent_ovf_q[eff_head];
            wb_err_inv = ent_inv_q[eff_head];
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (win_vec[i]) begin
                    s_we       = 1'b1;
                    s_waddr    = src_rd_a[i];
                    s_wdata    = src_data_a[i];
                    wb_src     = SRC_W'(i);
                    wb_err_ovf = src_ovf[i];
                    wb_err_inv = src_inv[i];
                end
            end
        end

        // Accepted loser of rank k lands at tail+k (mod depth)
        for (int j = 0; j < PEND_DEPTH; j++) begin
            ent_we[j]     = 1'b0;
            ent_rd_d[j]   = '0;
            ent_data_d[j] = '0;
            ent_src_d[j]  = '0;
            ent_ovf_d[j]  = 1'b0;
            ent_inv_d[j]  = 1'b0;
            off = (j - int'(eff_tail) + PEND_DEPTH) % PEND_DEPTH;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (acc_vec[i] && (rank_a[i] == off)) begin
                    ent_we[j]     = 1'b1;
                    ent_rd_d[j]   = src_rd_a[i];
                    ent_data_d[j] = src_data_a[i];
                    ent_src_d[j]  = SRC_W'(i);
                    ent_ovf_d[j]  = src_ovf[i];
                    ent_inv_d[j]  = src_inv[i];
                end
            end
        end

        head_d  = pop ? PTR_W'((int'(eff_head) + 1) % PEND_DEPTH) : eff_head;
        tail_d  = PTR_W'((int'(eff_tail) + n_acc) % PEND_DEPTH);
        count_d = CNT_W'(int'(eff_count) - (pop ? 1 : 0) + n_acc);

        pend_count = eff_count;
        idle       = fifo_empty && !byp_valid && !(|src_valid);
    end

    int boff;

    // Busy bitmap decoded from the currently valid FIFO entries
    always_comb begin
        pend_busy = '0;
        for (int j = 0; j < PEND_DEPTH; j++) begin
            boff = (j - int'(eff_head) + PEND_DEPTH) % PEND_DEPTH;
            if (boff < int'(eff_count)) begin
                pend_busy[ent_rd_q[j]] = 1'b1;
            end
        end
        pend_busy[0] = 1'b0;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < PEND_DEPTH; gi++) begin : g_entry
            // Payload capture for one FIFO slot
            always_ff @(posedge clk) begin
                if (ent_we[gi]) begin
                    ent_rd_q[gi]   <= ent_rd_d[gi];
                    ent_data_q[gi] <= ent_data_d[gi];
                    ent_src_q[gi]  <= ent_src_d[gi];
                    ent_ovf_q[gi]  <= ent_ovf_d[gi];
                    ent_inv_q[gi]  <= ent_inv_d[gi];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_scalar_wb_arb_nq.sv
// Directed bench for scalar_wb_arb_nq (NUM_SRC=3, PEND_DEPTH=4).
module tb_scalar_wb_arb_nq;

    localparam int NUM_SRC    = 3;
    localparam int DATA_W     = 32;
    localparam int PEND_DEPTH = 4;
    localparam int SRC_W      = 2;
    localparam int CNT_W      = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      byp_valid;
    logic [4:0]                byp_rd;
    logic [DATA_W-1:0]         byp_data;
    logic [NUM_SRC-1:0]        src_valid;
    logic [5*NUM_SRC-1:0]      src_rd;
    logic [DATA_W*NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ovf;
    logic [NUM_SRC-1:0]        src_inv;
    logic [NUM_SRC-1:0]        src_ready;
    logic                      s_we;
    logic [4:0]                s_waddr;
    logic [DATA_W-1:0]         s_wdata;
    logic [SRC_W-1:0]          wb_src;
    logic                      wb_err_ovf;
    logic                      wb_err_inv;
    logic [CNT_W-1:0]          pend_count;
    logic [31:0]               pend_busy;
    logic                      idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scalar_wb_arb_nq #(
        .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .PEND_DEPTH(PEND_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data),
        .src_valid(src_valid), .src_rd(src_rd), .src_data(src_data),
        .src_ovf(src_ovf), .src_inv(src_inv), .src_ready(src_ready),
        .s_we(s_we), .s_waddr(s_waddr), .s_wdata(s_wdata), .wb_src(wb_src),
        .wb_err_ovf(wb_err_ovf), .wb_err_inv(wb_err_inv),
        .pend_count(pend_count), .pend_busy(pend_busy), .idle(idle)
    );

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        byp_valid = 1'b0; byp_rd = '0; byp_data = '0;
        src_valid = '0; src_rd = '0; src_data = '0;
        src_ovf = '0; src_inv = '0;
    endtask

    task automatic set_src(input int i, input logic [4:0] rd, input logic ovf, input logic inv);
        src_valid[i]              = 1'b1;
        src_rd[5*i +: 5]          = rd;
        src_data[DATA_W*i +: DATA_W] = 32'hA000_0000 | 32'(rd);
        src_ovf[i]                = ovf;
        src_inv[i]                = inv;
    endtask

    task automatic drop_src(input int i);
        src_valid[i] = 1'b0;
        src_rd[5*i +: 5] = '0;
        src_ovf[i] = 1'b0;
        src_inv[i] = 1'b0;
    endtask

    task automatic set_byp(input logic [4:0] rd);
        byp_valid = 1'b1;
        byp_rd    = rd;
        byp_data  = 32'hB000_0000 | 32'(rd);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++;
        if (s_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", s_we); end
        checks++;
        if (pend_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", pend_count); end
        checks++;
        if (pend_busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", pend_busy); end
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b want 1", idle); end
        checks++;
        if (src_ready !== 3'b111) begin errors++; $display("FAIL reset_ready: got %b want 111", src_ready); end
    endtask

    task automatic test_collision();
        logic [4:0] exp_rd  [3];
        logic [1:0] exp_src [3];
        logic [CNT_W-1:0] exp_cnt [3];
        logic [31:0] exp_busy [3];
        exp_rd = '{5'd6, 5'd7, 5'd8};
        exp_src = '{2'd0, 2'd1, 2'd2};
        exp_cnt = '{3'd3, 3'd2, 3'd1};
        exp_busy = '{32'h1C0, 32'h180, 32'h100};
        tick();
        set_byp(5'd5); set_src(0, 5'd6, 1'b0, 1'b0); set_src(1, 5'd7, 1'b0, 1'b0); set_src(2, 5'd8, 1'b0, 1'b0);
        #1;
        checks++;
        if ({s_we, s_waddr, s_wdata, wb_src} !== {1'b1, 5'd5, 32'hB000_0005, 2'd3})
            begin errors++; $display("FAIL coll_byp: got we=%0b rd=%0d d=%h src=%0d want we=1 rd=5 d=b0000005 src=3", s_we, s_waddr, s_wdata, wb_src); end
        checks++;
        if (src_ready !== 3'b111) begin errors++; $display("FAIL coll_ready: got %b want 111", src_ready); end
        tick();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({s_we, s_waddr, s_wdata, wb_src} !== {1'b1, exp_rd[k], 32'hA000_0000 | 32'(exp_rd[k]), exp_src[k]})
                begin errors++; $display("FAIL coll_drain%0d: got we=%0b rd=%0d d=%h src=%0d want rd=%0d src=%0d", k, s_we, s_waddr, s_wdata, wb_src, exp_rd[k], exp_src[k]); end
            checks++;
            if ({pend_count, pend_busy} !== {exp_cnt[k], exp_busy[k]})
                begin errors++; $display("FAIL coll_state%0d: got cnt=%0d busy=%h want cnt=%0d busy=%h", k, pend_count, pend_busy, exp_cnt[k], exp_busy[k]); end
            tick();
        end
        #1;
        checks++;
        if ({s_we, pend_count, idle} !== {1'b0, 3'd0, 1'b1})
            begin errors++; $display("FAIL coll_end: got we=%0b cnt=%0d idle=%0b want 0 0 1", s_we, pend_count, idle); end
    endtask

    task automatic test_fill_and_wrap();
        logic [4:0] exp_rd  [4];
        logic [1:0] exp_src [4];
        exp_rd = '{5'd12, 5'd13, 5'd14, 5'd15};
        exp_src = '{2'd2, 2'd0, 2'd1, 2'd2};
        // cycle 1: bypass busy, all three park
        tick();
        set_byp(5'd1); set_src(0, 5'd10, 1'b0, 1'b0); set_src(1, 5'd11, 1'b0, 1'b0); set_src(2, 5'd12, 1'b0, 1'b0);
        #1;
        checks++;
        if ({src_ready, s_waddr} !== {3'b111, 5'd1})
            begin errors++; $display("FAIL fill_c1: got ready=%b rd=%0d want ready=111 rd=1", src_ready, s_waddr); end
        // cycle 2: one slot left, only src0 fits
        tick();
        set_byp(5'd2); set_src(0, 5'd13, 1'b0, 1'b0); set_src(1, 5'd14, 1'b0, 1'b0); set_src(2, 5'd15, 1'b0, 1'b0);
        #1;
        checks++;
        if ({src_ready, pend_count} !== {3'b001, 3'd3})
            begin errors++; $display("FAIL fill_c2: got ready=%b cnt=%0d want ready=001 cnt=3", src_ready, pend_count); end
        // cycle 3: full, no pop, src1/src2 keep holding
        tick();
        drop_src(0);
        #1;
        checks++;
        if ({src_ready, pend_count, pend_busy} !== {3'b001, 3'd4, 32'h3C00})
            begin errors++; $display("FAIL full_hold: got ready=%b cnt=%0d busy=%h want 001 4 00003c00", src_ready, pend_count, pend_busy); end
        // cycle 4: bypass drops, head pops, only src1 accepted
        tick();
        byp_valid = 1'b0; byp_rd = '0; byp_data = '0;
        #1;
        checks++;
        if ({s_we, s_waddr, s_wdata, wb_src} !== {1'b1, 5'd10, 32'hA000_000A, 2'd0})
            begin errors++; $display("FAIL full_pop: got we=%0b rd=%0d d=%h src=%0d want rd=10 src=0", s_we, s_waddr, s_wdata, wb_src); end
        checks++;
        if (src_ready !== 3'b011) begin errors++; $display("FAIL full_push_ready: got %b want 011", src_ready); end
        // cycle 5: src2 gets the slot freed by the next pop
        tick();
        drop_src(1);
        #1;
        checks++;
        if ({pend_count, src_ready, s_waddr, wb_src} !== {3'd4, 3'b111, 5'd11, 2'd1})
            begin errors++; $display("FAIL full_pop2: got cnt=%0d ready=%b rd=%0d src=%0d want 4 111 11 1", pend_count, src_ready, s_waddr, wb_src); end
        tick();
        drop_src(2);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if ({s_we, s_waddr, s_wdata, wb_src} !== {1'b1, exp_rd[k], 32'hA000_0000 | 32'(exp_rd[k]), exp_src[k]})
                begin errors++; $display("FAIL wrap_drain%0d: got we=%0b rd=%0d d=%h src=%0d want rd=%0d src=%0d", k, s_we, s_waddr, s_wdata, wb_src, exp_rd[k], exp_src[k]); end
            tick();
        end
        #1;
        checks++;
        if ({s_we, pend_count} !== {1'b0, 3'd0})
            begin errors++; $display("FAIL wrap_end: got we=%0b cnt=%0d want 0 0", s_we, pend_count); end
    endtask

    task automatic test_x0();
        tick();
        set_src(0, 5'd0, 1'b0, 1'b0); set_src(1, 5'd9, 1'b0, 1'b0);
        #1;
        checks++;
        if ({s_we, s_waddr, s_wdata, wb_src, src_ready} !== {1'b1, 5'd9, 32'hA000_0009, 2'd1, 3'b111})
            begin errors++; $display("FAIL x0_src: got we=%0b rd=%0d d=%h src=%0d ready=%b want 1 9 a0000009 1 111", s_we, s_waddr, s_wdata, wb_src, src_ready); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (pend_count !== 3'd0) begin errors++; $display("FAIL x0_count: got %0d want 0", pend_count); end
        // bypass to x0 gives up the port to src0
        tick();
        set_byp(5'd0); set_src(0, 5'd4, 1'b0, 1'b0);
        #1;
        checks++;
        if ({s_we, s_waddr, wb_src, src_ready} !== {1'b1, 5'd4, 2'd0, 3'b111})
            begin errors++; $display("FAIL x0_byp_pass: got we=%0b rd=%0d src=%0d ready=%b want 1 4 0 111", s_we, s_waddr, wb_src, src_ready); end
        tick();
        drop_src(0);
        #1;
        checks++;
        if ({s_we, s_waddr, s_wdata, wb_src, idle} !== {1'b0, 5'd0, 32'd0, 2'd0, 1'b0})
            begin errors++; $display("FAIL x0_byp_alone: got we=%0b rd=%0d d=%h src=%0d idle=%0b want all 0", s_we, s_waddr, s_wdata, wb_src, idle); end
        tick();
        clear_inputs();
    endtask

    task automatic test_err_align();
        set_byp(5'd3); set_src(1, 5'd20, 1'b1, 1'b0);
        #1;
        checks++;
        if ({s_waddr, wb_err_ovf, wb_err_inv, src_ready} !== {5'd3, 1'b0, 1'b0, 3'b111})
            begin errors++; $display("FAIL err_byp: got rd=%0d ovf=%0b inv=%0b ready=%b want 3 0 0 111", s_waddr, wb_err_ovf, wb_err_inv, src_ready); end
        tick();
        clear_inputs();
        #1;
        checks++;
        if ({s_we, s_waddr, wb_src, wb_err_ovf, wb_err_inv} !== {1'b1, 5'd20, 2'd1, 1'b1, 1'b0})
            begin errors++; $display("FAIL err_retire: got we=%0b rd=%0d src=%0d ovf=%0b inv=%0b want 1 20 1 1 0", s_we, s_waddr, wb_src, wb_err_ovf, wb_err_inv); end
        tick();
        checks++;
        if ({s_we, wb_err_ovf, wb_err_inv} !== 3'b000)
            begin errors++; $display("FAIL err_after: got we=%0b ovf=%0b inv=%0b want 0 0 0", s_we, wb_err_ovf, wb_err_inv); end
        set_src(2, 5'd21, 1'b0, 1'b1);
        #1;
        checks++;
        if ({s_waddr, wb_src, wb_err_ovf, wb_err_inv} !== {5'd21, 2'd2, 1'b0, 1'b1})
            begin errors++; $display("FAIL err_direct: got rd=%0d src=%0d ovf=%0b inv=%0b want 21 2 0 1", s_waddr, wb_src, wb_err_ovf, wb_err_inv); end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        set_byp(5'd5); set_src(0, 5'd6, 1'b0, 1'b0);
        tick();
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if ({s_we, pend_count, pend_busy} !== {1'b0, 3'd0, 32'h0})
            begin errors++; $display("FAIL rst_mid_during: got we=%0b cnt=%0d busy=%h want 0 0 0", s_we, pend_count, pend_busy); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({s_we, pend_count, pend_busy, idle} !== {1'b0, 3'd0, 32'h0, 1'b1})
            begin errors++; $display("FAIL rst_mid_after: got we=%0b cnt=%0d busy=%h idle=%0b want 0 0 0 1", s_we, pend_count, pend_busy, idle); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_collision();
        test_fill_and_wrap();
        test_x0();
        test_err_align();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
